// File: rtl/fx3_uart_pkg.sv
// Shared types and helpers for the FX3 control-link UART blocks.
package fx3_uart_pkg;

   // Parity mode encoding, matches the integer PARITY parameter values
   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   // Receiver frame states
   typedef enum logic [2:0] {
      ST_WAIT_HIGH = 3'd0,
      ST_IDLE      = 3'd1,
      ST_START     = 3'd2,
      ST_DATA      = 3'd3,
      ST_PARITY    = 3'd4,
      ST_STOP      = 3'd5
   } rx_state_e;

   // 2-of-3 vote used to resolve each bit from its three centre samples
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/fx3_uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every CLK_DIVISOR clocks,
// restartable so the receiver can phase-align to a start edge.
module fx3_uart_baud_tick #(
   parameter int CLK_DIVISOR = 54
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic restart_i,
   output logic tick_o
);

   localparam int CW = (CLK_DIVISOR > 2) ? $clog2(CLK_DIVISOR) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIVISOR - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: restart wins, otherwise wrap at CNT_LAST
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart_i) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end
   end

   // Counter register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/fx3_uart_rx.sv
// Parametrised UART receiver: oversampled, 3-sample majority per bit,
// optional parity, 1 or 2 stop bits, framing/parity error pulses.
module fx3_uart_rx
   import fx3_uart_pkg::*;
#(
   parameter int CLK_DIVISOR = 54,
   parameter int OVERSAMPLE  = 16,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk_100,
   input  logic                 reset,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_data_valid,
   output logic                 parity_error,
   output logic                 frame_error,
   output logic                 rx_busy
);

   localparam int OSW = $clog2(OVERSAMPLE);
   localparam int BCW = $clog2(DATA_BITS + 1);
   localparam logic [OSW-1:0] SAMP_A  = OSW'(OVERSAMPLE / 2 - 1);
   localparam logic [OSW-1:0] SAMP_B  = OSW'(OVERSAMPLE / 2);
   localparam logic [OSW-1:0] SAMP_C  = OSW'(OVERSAMPLE / 2 + 1);
   localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
   localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
   localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
   localparam parity_e PAR_MODE = parity_e'(PARITY[1:0]);

   rx_state_e            state_q, state_d;
   logic [1:0]           sync_q;
   logic                 rx_s;
   logic                 tick;
   logic                 start_det;
   logic                 decide;
   logic                 bit_end;
   logic                 maj;
   logic                 par_exp;
   logic                 done;
   logic [OSW-1:0]       os_cnt_q;
   logic [BCW-1:0]       bit_cnt_q;
   logic [1:0]           samp_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_bad_q;
   logic [DATA_BITS-1:0] rx_data_q;
   logic                 valid_q, perr_q, ferr_q;
   logic                 valid_d, perr_d, ferr_d;

   // Two-flop synchroniser; idles high so reset does not look like a start bit
   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], uart_rx};
      end
   end
   assign rx_s = sync_q[1];

   assign start_det = (state_q == ST_IDLE) && !rx_s;

   fx3_uart_baud_tick #(
      .CLK_DIVISOR (CLK_DIVISOR)
   ) u_tick (
      .clk_i     (clk_100),
      .rst_i     (reset),
      .restart_i (start_det),
      .tick_o    (tick)
   );

   assign decide  = tick && (os_cnt_q == SAMP_C);
   assign bit_end = tick && (os_cnt_q == OS_LAST);
   assign maj     = majority3(samp_q[0], samp_q[1], rx_s);
   assign par_exp = (PAR_MODE == PAR_ODD) ? ~^shift_q : ^shift_q;

   // Bit timing, sampling and data shifting; bit_cnt restarts whenever the FSM changes phase
   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset) begin
         os_cnt_q  <= '0;
         bit_cnt_q <= '0;
         samp_q    <= 2'b11;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
      end else if (start_det) begin
         os_cnt_q  <= '0;
         bit_cnt_q <= '0;
         par_bad_q <= 1'b0;
      end else begin
         if (tick) begin
            os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
         end
         if (tick && (os_cnt_q == SAMP_A)) begin
            samp_q[0] <= rx_s;
         end
         if (tick && (os_cnt_q == SAMP_B)) begin
            samp_q[1] <= rx_s;
         end
         if (decide && (state_q == ST_DATA)) begin
            shift_q <= {maj, shift_q[DATA_BITS-1:1]};
         end
         if (decide && (state_q == ST_PARITY)) begin
            par_bad_q <= (maj != par_exp);
         end
         if (bit_end) begin
            bit_cnt_q <= (state_d != state_q) ? '0 : bit_cnt_q + 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset) begin
         state_q <= ST_WAIT_HIGH;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; the last good stop bit returns to IDLE at its decision point
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT_HIGH: if (rx_s) state_d = ST_IDLE;
         ST_IDLE:      if (!rx_s) state_d = ST_START;
         ST_START: begin
            if (decide && maj) begin
               state_d = ST_IDLE;
            end else if (bit_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end && (bit_cnt_q == DATA_LAST)) begin
               state_d = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
         end
         ST_PARITY:    if (bit_end) state_d = ST_STOP;
         ST_STOP: begin
            if (decide) begin
               if (!maj) begin
                  state_d = ST_WAIT_HIGH;
               end else if (bit_cnt_q == STOP_LAST) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default:      state_d = ST_WAIT_HIGH;
      endcase
   end

   // FSM outputs: completion classification, frame error overrides parity error
   always_comb begin
      done    = (state_q == ST_STOP) && decide && (!maj || (bit_cnt_q == STOP_LAST));
      valid_d = done && maj && !par_bad_q;
      perr_d  = done && maj && par_bad_q;
      ferr_d  = done && !maj;
      rx_busy = (state_q != ST_IDLE);
   end

   // Registered result word and one-cycle status pulses
   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset) begin
         rx_data_q <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         if (done) begin
            rx_data_q <= shift_q;
         end
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_data_valid = valid_q;
   assign parity_error  = perr_q;
   assign frame_error   = ferr_q;

endmodule

// File: tb/tb_fx3_uart_rx.sv
// Directed bench for fx3_uart_rx: a default 8N1 instance and a fast 7E2 instance.
module tb_fx3_uart_rx;

   localparam int BIT0 = 54 * 16;
   localparam int BIT1 = 4 * 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, rst1, line0, line1;
   logic [7:0] data0;
   logic [6:0] data1;
   logic       v0, pe0, fe0, busy0;
   logic       v1, pe1, fe1, busy1;

   fx3_uart_rx u_dut0 (
      .clk_100(clk), .reset(rst0), .uart_rx(line0), .rx_data(data0),
      .rx_data_valid(v0), .parity_error(pe0), .frame_error(fe0), .rx_busy(busy0)
   );

   fx3_uart_rx #(
      .CLK_DIVISOR(4), .OVERSAMPLE(8), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
   ) u_dut1 (
      .clk_100(clk), .reset(rst1), .uart_rx(line1), .rx_data(data1),
      .rx_data_valid(v1), .parity_error(pe1), .frame_error(fe1), .rx_busy(busy1)
   );

   int cyc = 0;
   int n_vec = 0;
   int n_bad = 0;
   int nv0 = 0, npe0 = 0, nfe0 = 0, tv0 = 0;
   int nv1 = 0, npe1 = 0, nfe1 = 0, tv1 = 0;
   int start_cyc = 0;
   int bv, bp, bf;
   logic [15:0] f;
   int nb;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse counters and timestamp of the latest valid pulse per instance
   always @(negedge clk) begin
      if (v0)  begin nv0 <= nv0 + 1; tv0 <= cyc; end
      if (pe0) npe0 <= npe0 + 1;
      if (fe0) nfe0 <= nfe0 + 1;
      if (v1)  begin nv1 <= nv1 + 1; tv1 <= cyc; end
      if (pe1) npe1 <= npe1 + 1;
      if (fe1) nfe1 <= nfe1 + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic drive(input int sel, input logic v);
      if (sel == 0) line0 = v;
      else line1 = v;
   endtask

   task automatic idle(input int sel, input int n);
      drive(sel, 1'b1);
      repeat (n) @(negedge clk);
   endtask

   task automatic build_frame(output logic [15:0] fr, output int nbits, input logic [8:0] d,
                              input int nd, input int par, input bit flip,
                              input logic [1:0] stops, input int nstop);
      int idx;
      logic p;
      fr = '1;
      fr[0] = 1'b0;
      for (int i = 0; i < nd; i++) fr[1+i] = d[i];
      idx = 1 + nd;
      if (par != 0) begin
         p = ^d;
         if (par == 1) p = ~p;
         fr[idx] = p ^ flip;
         idx++;
      end
      for (int s = 0; s < nstop; s++) begin
         fr[idx] = stops[s];
         idx++;
      end
      nbits = idx;
   endtask

   // Sends the first nbits of a frame; bits spk_first..spk_last get an inverted spike
   task automatic send_frame(input int sel, input logic [15:0] fr, input int nbits, input int bitcyc,
                             input int spk_first, input int spk_last,
                             input int spk_start, input int spk_len);
      @(negedge clk);
      start_cyc = cyc;
      for (int b = 0; b < nbits; b++) begin
         if (b >= spk_first && b <= spk_last) begin
            drive(sel, fr[b]);
            repeat (spk_start) @(negedge clk);
            drive(sel, ~fr[b]);
            repeat (spk_len) @(negedge clk);
            drive(sel, fr[b]);
            repeat (bitcyc - spk_start - spk_len) @(negedge clk);
         end else begin
            drive(sel, fr[b]);
            repeat (bitcyc) @(negedge clk);
         end
      end
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; line0 = 1'b1; line1 = 1'b1;
      repeat (5) @(negedge clk);
      check("reset busy0", busy0, 1);
      check("reset data0", data0, 0);
      check("reset valid0", v0, 0);
      check("reset busy1", busy1, 1);
      check("reset data1", data1, 0);
      rst0 = 1'b0; rst1 = 1'b0;
      repeat (20) @(negedge clk);
      check("idle busy0", busy0, 0);
      check("idle busy1", busy1, 0);

      // 0xA5 8N1 with latency
      bv = nv0; bp = npe0; bf = nfe0;
      build_frame(f, nb, 9'h0A5, 8, 0, 1'b0, 2'b11, 1);
      send_frame(0, f, nb, BIT0, -1, -1, 0, 0);
      idle(0, 100);
      check("a5 valid count", nv0 - bv, 1);
      check("a5 latency", tv0 - start_cyc, 2 + 8317);
      check("a5 data", data0, 8'hA5);
      check("a5 error pulses", (npe0 - bp) + (nfe0 - bf), 0);

      // half-bit start glitch
      bv = nv0; bp = npe0; bf = nfe0;
      @(negedge clk);
      drive(0, 1'b0);
      repeat (200) @(negedge clk);
      check("glitch busy mid", busy0, 1);
      repeat (232) @(negedge clk);
      idle(0, 600);
      check("glitch pulses", (nv0 - bv) + (npe0 - bp) + (nfe0 - bf), 0);
      check("glitch busy after", busy0, 0);

      // 0x3C with single-tick spikes on each data bit centre sample
      bv = nv0; bp = npe0; bf = nfe0;
      build_frame(f, nb, 9'h03C, 8, 0, 1'b0, 2'b11, 1);
      send_frame(0, f, nb, BIT0, 1, 8, 462, 54);
      idle(0, 100);
      check("spike valid count", nv0 - bv, 1);
      check("spike data", data0, 8'h3C);
      check("spike error pulses", (npe0 - bp) + (nfe0 - bf), 0);

      // 7E2 good frame 0x07 with latency (k=86, div=4)
      bv = nv1; bp = npe1; bf = nfe1;
      build_frame(f, nb, 9'h007, 7, 2, 1'b0, 2'b11, 2);
      send_frame(1, f, nb, BIT1, -1, -1, 0, 0);
      idle(1, 20);
      check("7e2 valid count", nv1 - bv, 1);
      check("7e2 latency", tv1 - start_cyc, 2 + 345);
      check("7e2 data", data1, 7'h07);
      check("7e2 error pulses", (npe1 - bp) + (nfe1 - bf), 0);

      // 0x41 with parity bit flipped
      bv = nv1; bp = npe1; bf = nfe1;
      build_frame(f, nb, 9'h041, 7, 2, 1'b1, 2'b11, 2);
      send_frame(1, f, nb, BIT1, -1, -1, 0, 0);
      idle(1, 20);
      check("par perr count", npe1 - bp, 1);
      check("par valid count", nv1 - bv, 0);
      check("par ferr count", nfe1 - bf, 0);
      check("par data", data1, 7'h41);

      // second stop bit low
      bv = nv1; bp = npe1; bf = nfe1;
      build_frame(f, nb, 9'h033, 7, 2, 1'b0, 2'b01, 2);
      send_frame(1, f, nb, BIT1, -1, -1, 0, 0);
      idle(1, 40);
      check("stop2 ferr count", nfe1 - bf, 1);
      check("stop2 valid count", nv1 - bv, 0);
      check("stop2 data", data1, 7'h33);

      // parity and stop errors together: frame error only
      bv = nv1; bp = npe1; bf = nfe1;
      build_frame(f, nb, 9'h011, 7, 2, 1'b1, 2'b10, 2);
      send_frame(1, f, nb, BIT1, -1, -1, 0, 0);
      idle(1, 40);
      check("both ferr count", nfe1 - bf, 1);
      check("both perr count", npe1 - bp, 0);

      // stop low, line held low 20 bits, then recover
      bv = nv1; bp = npe1; bf = nfe1;
      build_frame(f, nb, 9'h055, 7, 2, 1'b0, 2'b00, 2);
      send_frame(1, f, 9, BIT1, -1, -1, 0, 0);
      drive(1, 1'b0);
      repeat (20 * BIT1) @(negedge clk);
      check("hold ferr count", nfe1 - bf, 1);
      check("hold other pulses", (nv1 - bv) + (npe1 - bp), 0);
      check("hold busy", busy1, 1);
      idle(1, 64);
      check("hold busy released", busy1, 0);
      bv = nv1;
      build_frame(f, nb, 9'h02A, 7, 2, 1'b0, 2'b11, 2);
      send_frame(1, f, nb, BIT1, -1, -1, 0, 0);
      idle(1, 20);
      check("recover valid count", nv1 - bv, 1);
      check("recover data", data1, 7'h2A);

      // reset during data bit 4
      bv = nv1; bp = npe1; bf = nfe1;
      build_frame(f, nb, 9'h06F, 7, 2, 1'b0, 2'b11, 2);
      send_frame(1, f, 5, BIT1, -1, -1, 0, 0);
      drive(1, f[5]);
      repeat (BIT1 / 2) @(negedge clk);
      rst1 = 1'b1;
      repeat (3) @(negedge clk);
      line1 = 1'b1;
      check("midreset busy", busy1, 1);
      check("midreset data", data1, 0);
      rst1 = 1'b0;
      repeat (14 * BIT1) @(negedge clk);
      check("midreset pulses", (nv1 - bv) + (npe1 - bp) + (nfe1 - bf), 0);
      build_frame(f, nb, 9'h05A, 7, 2, 1'b0, 2'b11, 2);
      send_frame(1, f, nb, BIT1, -1, -1, 0, 0);
      idle(1, 20);
      check("post reset valid count", nv1 - bv, 1);
      check("post reset data", data1, 7'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fx3_uart_rx.md
# fx3_uart_rx

Parametrised UART receiver for the FX3 control link, replacing the fixed 8N1 receiver. It runs entirely in the `clk_100` domain with a synchronous oversampling tick; no derived clocks are used. It supports configurable data width, parity, stop bits and oversampling ratio, uses 3-sample majority voting, and reports framing and parity errors. It sits between the FX3 UART pin and the command decoder.

## Interface
- `CLK_DIVISOR`, 54: `clk_100` cycles per oversample tick (≥2).
- `OVERSAMPLE`, 16: ticks per bit; even, ≥8.
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `clk_100`  in  1  system clock; only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  DATA_BITS  last received word; reset 0; held until next frame completes.
- `rx_data_valid`  out  1  one-cycle pulse, good frame; reset 0.
- `parity_error`  out  1  one-cycle pulse, parity mismatch; reset 0.
- `frame_error`  out  1  one-cycle pulse, stop bit sampled 0; reset 0.
- `rx_busy`  out  1  high in any state except IDLE; reset 1 (state WAIT_HIGH).

## Operation
- `uart_rx` passes through a 2-flop synchroniser (reset value 1) to give `rx_s`; all logic uses `rx_s`.
- Tick generator: counter 0..CLK_DIVISOR-1, `tick` when count = CLK_DIVISOR-1. It restarts at 0 in the cycle a start edge is detected.
- Bit phase counter `os_cnt`, 0..OVERSAMPLE-1, advances per tick.
- In each bit, samples are taken at `os_cnt` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the 3 samples, decided at the third sample.
- States:
  - WAIT_HIGH: entered at reset and after a frame error. Goes to IDLE when `rx_s` = 1.
  - IDLE: goes to START when `rx_s` = 0, with tick counter and `os_cnt` cleared.
  - START: if the majority is 1 (glitch), go to IDLE with no outputs. If 0, continue; go to DATA when `os_cnt` wraps.
  - DATA: shift DATA_BITS values LSB first. Then go to PARITY if PARITY≠0, else STOP.
  - PARITY: compare the sampled bit with the computed parity. Odd parity means data plus parity has an odd number of ones.
  - STOP: evaluated at each stop bit's decision point.
    - Any stop bit 0: raise `frame_error` and go to WAIT_HIGH.
    - Last stop bit 1: go to IDLE at the decision point, not at bit end, to allow back-to-back resync.
- Completion is the cycle after the final stop decision. In that cycle:
  - `rx_data` loads the shifted word, including on errors.
  - Exactly one of `rx_data_valid`, `parity_error` or `frame_error` pulses.
  - If both parity and frame errors occur, only `frame_error` pulses.
- Reset mid-frame: the partial frame is discarded, all outputs return to their reset values, and the FSM enters WAIT_HIGH.

## Timing
- Latency: `uart_rx` falling edge → `rx_s` low is 2 cycles. Detection happens in the cycle `rx_s` first reads 0.
- Let F = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS - 1 be the bit index of the last stop bit.
- The final decision tick is k = F·OVERSAMPLE + OVERSAMPLE/2 + 2, occurring k·CLK_DIVISOR cycles after detection. Outputs pulse 1 cycle later.
- Defaults (8N1): k = 154, so the pulse comes 8317 cycles after detection.
- Output pulses are exactly 1 `clk_100` cycle wide. There is no back-pressure: the consumer must capture on the pulse.
- Minimum frame spacing: a new start edge is accepted from the cycle after the final stop decision.

## Structure
- Package `fx3_uart_pkg` holds:
  - the parity enum (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`);
  - the FSM state enum;
  - a `majority3` function.
- Sub-module `fx3_uart_baud_tick`: divider with synchronous restart input and `tick` output. The future TX block reuses it.

## Test plan
- Defaults, send 0xA5 8N1 at 115200 baud → `rx_data` = 0xA5. `rx_data_valid` pulses once, 8317 cycles after detection. No error pulses.
- 0.5-bit (8-tick) low glitch on an idle line → no output pulse, FSM back in IDLE, `rx_busy` low after the glitch.
- PARITY = 2, DATA_BITS = 7, send 0x41 with the parity bit flipped → `parity_error` pulse, `rx_data` = 0x41, no `rx_data_valid`.
- Stop bit driven 0, line held low for 20 bits, then high → single `frame_error` pulse. No new frame until the line goes high, and the next frame is received correctly.
- Single-tick inverted spikes at the centre sample of each data bit of 0x3C → majority voting rejects them; `rx_data` = 0x3C, valid pulse.
- Assert `reset` during data bit 4, release with the line high, then send 0x5A → no pulse from the aborted frame, then 0x5A received with `rx_data_valid`.
